hdmi_rd_sched: RTL and testbench
================================

# hdmi_rd_sched

Read-burst scheduler for the dual-camera HDMI path. It shares one frame-buffer read port between two per-camera line FIFOs, cam0 (left half of the screen) and cam1 (right half). It issues fixed-length read bursts round-robin, whenever a FIFO has room and its frame is not yet fully read. It sits between the DDR read-port adapter and the two line FIFOs that feed the HDMI overlay/display stage.

## Interface
- ADDR_W, 28, frame-buffer address width, in beats
- BURST_LEN, 64, beats per full burst (1 beat = 8 pixels × 16 bit)
- FIFO_DEPTH, 512, line FIFO depth in beats
- LVL_W, 10, FIFO level width (covers 0..FIFO_DEPTH)
---
- hdmi_clk  in  1  clock
- sys_rst_n  in  1  asynchronous, active-low reset
- frame_start  in  1  one-cycle pulse at HDMI vsync; restarts both frames
- rd_h_pixel  in  13  full output width in pixels; each camera supplies rd_h_pixel/2
- rd_v_pixel  in  13  output height in lines
- base0, base1  in  ADDR_W  frame-buffer base address for cam0 / cam1
- fifo0_level, fifo1_level  in  LVL_W  current fill of each line FIFO, in beats
- rd_req  out  1  burst request
- rd_addr  out  ADDR_W  burst start address
- rd_len  out  8  burst length in beats, 1..BURST_LEN
- rd_sel  out  1  target FIFO: 0 = cam0, 1 = cam1
- rd_ack  in  1  port accepted the request
- rd_done  in  1  last beat of the current burst has been written to the FIFO
- busy  out  1  high in REQ or WAIT

## Operation
- frame_beats = ((rd_h_pixel>>1) × rd_v_pixel) >> 3.
  - 24 bit, unsigned.
  - Registered on frame_start, or on pending-frame apply.
- Per-camera offset counters off0 and off1, 24 bit, in beats.
- Camera n is eligible when:
  - fifoN_level ≤ FIFO_DEPTH − BURST_LEN, and
  - offN < frame_beats.
- Arbitration is round-robin:
  - The rr pointer holds the last granted camera.
  - If both cameras are eligible, grant the one that is not rr.
  - If one is eligible, grant it.
- Burst length: len = min(BURST_LEN, frame_beats − offN).
- Burst address: rd_addr = baseN + offN, truncated to ADDR_W.
- FSM:
  - IDLE: if pend or frame_start, load frame_beats, clear off0/off1, clear pend, set rr=1, stay in IDLE. Else, if a grant exists, register rd_addr/rd_len/rd_sel, set rd_req=1, go to REQ.
  - REQ: hold rd_req and all rd_* fields stable until rd_ack. On rd_ack, drop rd_req and go to WAIT. If rd_ack and rd_done arrive in the same cycle, treat it as WAIT completion directly.
  - WAIT: on rd_done, offN += rd_len, rr = rd_sel, go to IDLE.
- frame_start in REQ or WAIT sets pend. The in-flight burst completes and its offset update still happens. The restart is applied on return to IDLE.
- rd_done outside WAIT (or the same-cycle REQ case) is ignored.
- rd_ack outside REQ is ignored.
- Reset mid-burst returns everything to reset values immediately. The port adapter is reset by the same sys_rst_n.

## Timing
- Reset values:
  - rd_req=0, rd_addr=0, rd_len=0, rd_sel=0, busy=0
  - off0=off1=0, frame_beats=0, rr=1, pend=0, state IDLE
  - Since frame_beats=0, nothing is eligible until the first frame_start.
- frame_start in IDLE at cycle t: the new frame_beats is visible at t+1. The earliest rd_req is at t+2.
- Eligible in IDLE at cycle t: rd_req=1 at t+1.
- rd_ack at t: rd_req=0 at t+1.
- rd_done at t: IDLE at t+1. The next rd_req is no earlier than t+2.
- Maximum one outstanding burst.
- Level inputs are sampled only in IDLE. The FIFO write side must count a burst's beats only after they arrive; no double-count guard exists in this block.

## Structure
- Package hdmi_rd_pkg holds:
  - State enum {IDLE, REQ, WAIT}
  - BEAT_PIX=8
  - OFF_W=24
  - Default ADDR_W and BURST_LEN
- Sub-module rr_arb2 is a 2-requester round-robin grant: inputs req[1:0] and last; outputs gnt_vld and gnt_idx.
- Everything else stays in hdmi_rd_sched.

## Test plan
- Basic frame, round-robin:
  - Stimulus: rd_h_pixel=1280, rd_v_pixel=720, both levels=0, frame_start, ack/done after 3/20 cycles.
  - Required: frame_beats=57600. Requests alternate sel 0,1,0,1… with addresses base+0, base+64, ….
  - Required: after 900 bursts per camera, no more requests.
- Partial last burst:
  - Stimulus: rd_h_pixel=20, rd_v_pixel=8.
  - Required: frame_beats=10, one burst per camera with rd_len=10, then idle.
- Backpressure:
  - Stimulus: fifo0_level=449, fifo1_level=0.
  - Required: only sel=1 bursts. When fifo0_level drops to 448, a sel=0 request appears within 1 cycle of returning to IDLE.
- Frame restart mid-burst:
  - Stimulus: frame_start while in WAIT, with off0=128.
  - Required: the burst completes and off0 becomes 192. Then both offsets clear, and the next request is sel=0 at base0+0.
- Handshake edge cases:
  - Stimulus: hold rd_ack low for 50 cycles.
  - Required: rd_req, rd_addr, rd_len and rd_sel stay stable.
  - Stimulus: rd_ack and rd_done in the same cycle.
  - Required: IDLE on the next cycle.
  - Stimulus: spurious rd_done in IDLE.
  - Required: no offset change.
- Reset mid-operation:
  - Stimulus: assert sys_rst_n low in REQ.
  - Required: all outputs go to reset values asynchronously. After release, no request until frame_start.

Source files
------------

// File: rtl/hdmi_rd_pkg.sv
// Shared types and constants for the HDMI frame-buffer read scheduler.
package hdmi_rd_pkg;
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } state_t;

   localparam int BEAT_PIX      = 8;
   localparam int OFF_W         = 24;
   localparam int ADDR_W_DEF    = 28;
   localparam int BURST_LEN_DEF = 64;
endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin grant; when both request, the one not granted last wins.
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic       gnt_vld,
   output logic       gnt_idx
);
   always_comb begin
      gnt_vld = |req;
      gnt_idx = 1'b0;
      if (req == 2'b11) gnt_idx = ~last;
      else              gnt_idx = req[1];
   end
endmodule

// File: rtl/hdmi_rd_sched.sv
// Read-burst scheduler sharing one frame-buffer read port between the cam0
// and cam1 line FIFOs, one outstanding burst at a time.
module hdmi_rd_sched
   import hdmi_rd_pkg::*;
#(
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int BURST_LEN  = BURST_LEN_DEF,
   parameter int FIFO_DEPTH = 512,
   parameter int LVL_W      = 10
) (
   input  logic              hdmi_clk,
   input  logic              sys_rst_n,
   input  logic              frame_start,
   input  logic [12:0]       rd_h_pixel,
   input  logic [12:0]       rd_v_pixel,
   input  logic [ADDR_W-1:0] base0,
   input  logic [ADDR_W-1:0] base1,
   input  logic [LVL_W-1:0]  fifo0_level,
   input  logic [LVL_W-1:0]  fifo1_level,
   output logic              rd_req,
   output logic [ADDR_W-1:0] rd_addr,
   output logic [7:0]        rd_len,
   output logic              rd_sel,
   input  logic              rd_ack,
   input  logic              rd_done,
   output logic              busy
);
   localparam int               BEAT_SH   = $clog2(BEAT_PIX);
   localparam logic [LVL_W-1:0] LVL_MAX   = LVL_W'(FIFO_DEPTH - BURST_LEN);
   localparam logic [OFF_W-1:0] BURST_OFF = OFF_W'(BURST_LEN);

   state_t            state;
   logic [OFF_W-1:0]  frame_beats;
   logic [OFF_W-1:0]  off0;
   logic [OFF_W-1:0]  off1;
   logic              rr;
   logic              pend;

   logic [24:0]       pix_prod;
   logic [OFF_W-1:0]  frame_beats_nxt;
   logic [1:0]        elig;
   logic              gnt_vld;
   logic              gnt_idx;
   logic [OFF_W-1:0]  gnt_off;
   logic [OFF_W-1:0]  remain;
   logic [ADDR_W-1:0] gnt_base;
   logic [7:0]        gnt_len;
   logic [OFF_W-1:0]  done_len;
   logic              finish;

   // Each camera covers half the output width; 8 pixels per beat.
   assign pix_prod        = 25'(rd_h_pixel >> 1) * 25'(rd_v_pixel);
   assign frame_beats_nxt = OFF_W'(pix_prod >> BEAT_SH);

   assign elig[0] = (fifo0_level <= LVL_MAX) && (off0 < frame_beats);
   assign elig[1] = (fifo1_level <= LVL_MAX) && (off1 < frame_beats);

   rr_arb2 u_arb (
      .req     (elig),
      .last    (rr),
      .gnt_vld (gnt_vld),
      .gnt_idx (gnt_idx)
   );

   assign gnt_off  = gnt_idx ? off1 : off0;
   assign gnt_base = gnt_idx ? base1 : base0;
   assign remain   = frame_beats - gnt_off;
   assign gnt_len  = (remain < BURST_OFF) ? remain[7:0] : 8'(BURST_LEN);
   assign done_len = OFF_W'(rd_len);

   // A done that arrives together with the ack closes the burst without visiting WAIT.
   assign finish = ((state == REQ) && rd_ack && rd_done) || ((state == WAIT) && rd_done);
   assign busy   = (state != IDLE);

   always_ff @(posedge hdmi_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state       <= IDLE;
         frame_beats <= '0;
         off0        <= '0;
         off1        <= '0;
         rr          <= 1'b1;
         pend        <= 1'b0;
         rd_req      <= 1'b0;
         rd_addr     <= '0;
         rd_len      <= '0;
         rd_sel      <= 1'b0;
      end else begin
         if (finish) begin
            if (rd_sel) off1 <= off1 + done_len;
            else        off0 <= off0 + done_len;
            rr <= rd_sel;
         end
         case (state)
            IDLE: begin
               if (pend || frame_start) begin
                  frame_beats <= frame_beats_nxt;
                  off0        <= '0;
                  off1        <= '0;
                  pend        <= 1'b0;
                  rr          <= 1'b1;
               end else if (gnt_vld) begin
                  rd_addr <= gnt_base + ADDR_W'(gnt_off);
                  rd_len  <= gnt_len;
                  rd_sel  <= gnt_idx;
                  rd_req  <= 1'b1;
                  state   <= REQ;
               end
            end
            REQ: begin
               if (frame_start) pend <= 1'b1;
               if (rd_ack) begin
                  rd_req <= 1'b0;
                  state  <= finish ? IDLE : WAIT;
               end
            end
            WAIT: begin
               // A restart here is deferred until the in-flight burst lands.
               if (frame_start) pend <= 1'b1;
               if (rd_done) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_hdmi_rd_sched.sv
// Randomized bench for hdmi_rd_sched against a burst-level model of frame progress.
module tb_hdmi_rd_sched;
   import hdmi_rd_pkg::*;

   localparam int ADDR_W     = 28;
   localparam int BURST_LEN  = 64;
   localparam int FIFO_DEPTH = 512;
   localparam int LVL_W      = 10;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              frame_start;
   logic [12:0]       h;
   logic [12:0]       v;
   logic [ADDR_W-1:0] base0;
   logic [ADDR_W-1:0] base1;
   logic [LVL_W-1:0]  lvl0;
   logic [LVL_W-1:0]  lvl1;
   logic              rd_req;
   logic [ADDR_W-1:0] rd_addr;
   logic [7:0]        rd_len;
   logic              rd_sel;
   logic              rd_ack;
   logic              rd_done;
   logic              busy;

   int total = 0;
   int bad   = 0;

   int unsigned fb_m;
   int unsigned off_m [2];
   bit          rr_m;
   bit          pend_m;
   int          exp_lat;

   always #5 clk = ~clk;

   hdmi_rd_sched #(
      .ADDR_W     (ADDR_W),
      .BURST_LEN  (BURST_LEN),
      .FIFO_DEPTH (FIFO_DEPTH),
      .LVL_W      (LVL_W)
   ) dut (
      .hdmi_clk    (clk),
      .sys_rst_n   (rst_n),
      .frame_start (frame_start),
      .rd_h_pixel  (h),
      .rd_v_pixel  (v),
      .base0       (base0),
      .base1       (base1),
      .fifo0_level (lvl0),
      .fifo1_level (lvl1),
      .rd_req      (rd_req),
      .rd_addr     (rd_addr),
      .rd_len      (rd_len),
      .rd_sel      (rd_sel),
      .rd_ack      (rd_ack),
      .rd_done     (rd_done),
      .busy        (busy)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d expected=%0d @%0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int unsigned frame_size(input int unsigned hp, input int unsigned vp);
      return ((hp / 2) * vp) / BEAT_PIX;
   endfunction

   task automatic model_restart();
      fb_m     = frame_size(int'(h), int'(v));
      off_m[0] = 0;
      off_m[1] = 0;
      rr_m     = 1'b1;
      pend_m   = 1'b0;
   endtask

   function automatic bit can_take(input int cam);
      int lvl;
      lvl = (cam == 1) ? int'(lvl1) : int'(lvl0);
      return (lvl <= FIFO_DEPTH - BURST_LEN) && (off_m[cam] < fb_m);
   endfunction

   task automatic start_frame();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      model_restart();
      check_val("fb_load", 32'(dut.frame_beats), fb_m);
      check_val("off_clr", 32'(dut.off0) + 32'(dut.off1), 0);
      exp_lat = 1;
   endtask

   // Plays the port adapter for up to max_n bursts, checking each request against the model.
   task automatic run_frame(input int ack_lo, input int ack_hi, input int done_lo, input int done_hi,
                            input int fs_n, input int drop_n, input int max_n, input bit rnd,
                            output int n);
      bit                e0, e1, vld, sel, same;
      int                lat, d;
      int unsigned       len;
      logic [ADDR_W-1:0] addr;
      n = 0;
      while (n < max_n) begin
         e0  = can_take(0);
         e1  = can_take(1);
         vld = e0 | e1;
         sel = (e0 && e1) ? !rr_m : e1;
         lat = 0;
         while (!rd_req && lat < 8) begin
            tick();
            lat++;
         end
         if (!vld) begin
            check_val("no_req", 32'(rd_req), 0);
            if (!rd_req && (off_m[0] < fb_m || off_m[1] < fb_m)) begin
               lvl0    = '0;
               lvl1    = '0;
               exp_lat = 1;
               continue;
            end
            break;
         end
         check_val("req_lat", 32'(lat), 32'(exp_lat));
         if (!rd_req) break;
         len  = (fb_m - off_m[sel] < BURST_LEN) ? fb_m - off_m[sel] : BURST_LEN;
         addr = (sel ? base1 : base0) + ADDR_W'(off_m[sel]);
         check_val("sel", 32'(rd_sel), 32'(sel));
         check_val("addr", 32'(rd_addr), 32'(addr));
         check_val("len", 32'(rd_len), len);
         check_val("busy_req", 32'(busy), 1);
         d = $urandom_range(ack_hi, ack_lo);
         for (int i = 0; i < d; i++) begin
            tick();
            check_val("hold_ctl", 32'({rd_req, rd_sel, rd_len}), 32'({1'b1, sel, 8'(len)}));
            check_val("hold_addr", 32'(rd_addr), 32'(addr));
         end
         same    = rnd && ($urandom_range(0, 3) == 0);
         rd_ack  = 1'b1;
         rd_done = same;
         tick();
         rd_ack  = 1'b0;
         rd_done = 1'b0;
         check_val("ack_drop", 32'(rd_req), 0);
         if (!same) begin
            d = $urandom_range(done_hi, done_lo);
            for (int i = 0; i < d; i++) begin
               if (i == 0 && n == fs_n) begin
                  if (rnd) begin
                     h = 13'(2 * $urandom_range(1, 150));
                     v = 13'($urandom_range(1, 12));
                  end
                  frame_start = 1'b1;
                  pend_m      = 1'b1;
               end
               if (i == 0 && n == drop_n) lvl0 = LVL_W'(FIFO_DEPTH - BURST_LEN);
               if (i == 0 && rnd && $urandom_range(0, 2) == 0) begin
                  lvl0 = LVL_W'($urandom_range(440, 460));
                  lvl1 = LVL_W'($urandom_range(440, 460));
               end
               tick();
               frame_start = 1'b0;
               check_val("busy_wait", 32'(busy), 1);
            end
            rd_done = 1'b1;
            tick();
            rd_done = 1'b0;
         end
         check_val("idle_after_done", 32'(busy), 0);
         off_m[sel] += len;
         rr_m = sel;
         check_val("off_upd", sel ? 32'(dut.off1) : 32'(dut.off0), off_m[sel]);
         if (pend_m) begin
            model_restart();
            exp_lat = 2;
         end else begin
            exp_lat = 1;
         end
         n++;
      end
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int nb, cnt;
      rst_n       = 1'b0;
      frame_start = 1'b0;
      rd_ack      = 1'b0;
      rd_done     = 1'b0;
      h           = 13'd20;
      v           = 13'd8;
      base0       = 28'h0100000;
      base1       = 28'h0800000;
      lvl0        = '0;
      lvl1        = '0;
      fb_m        = 0;
      off_m[0]    = 0;
      off_m[1]    = 0;
      rr_m        = 1'b1;
      pend_m      = 1'b0;
      exp_lat     = 1;
      #2;
      check_val("rst_req", 32'(rd_req), 0);
      check_val("rst_fields", 32'({rd_sel, rd_len, busy}), 0);
      check_val("rst_addr", 32'(rd_addr), 0);
      tick();
      tick();
      rst_n = 1'b1;
      cnt = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (rd_req) cnt++;
      end
      check_val("no_req_before_frame", 32'(cnt), 0);

      // Partial last burst: 10 beats per camera.
      start_frame();
      check_val("fb_partial", 32'(dut.frame_beats), 10);
      run_frame(1, 2, 1, 3, -1, -1, 100, 1'b0, nb);
      check_val("partial_bursts", 32'(nb), 2);
      rd_done = 1'b1;
      tick();
      rd_done = 1'b0;
      tick();
      check_val("spurious_done_off0", 32'(dut.off0), 10);
      check_val("spurious_done_off1", 32'(dut.off1), 10);
      check_val("spurious_done_req", 32'(rd_req), 0);

      // Backpressure on cam0 until its level falls to the threshold.
      h    = 13'd64;
      v    = 13'd64;
      lvl0 = LVL_W'(449);
      lvl1 = '0;
      start_frame();
      run_frame(0, 2, 1, 3, -1, 1, 100, 1'b0, nb);
      check_val("bp_bursts", 32'(nb), 8);

      // Full 1280x720 frame.
      h    = 13'd1280;
      v    = 13'd720;
      lvl0 = '0;
      lvl1 = '0;
      start_frame();
      check_val("fb_720p", 32'(dut.frame_beats), 57600);
      run_frame(3, 3, 5, 5, -1, -1, 4000, 1'b0, nb);
      check_val("720p_bursts", 32'(nb), 1800);
      check_val("720p_off0", 32'(dut.off0), 57600);
      check_val("720p_off1", 32'(dut.off1), 57600);

      // Long ack stall.
      h = 13'd16;
      v = 13'd8;
      start_frame();
      run_frame(50, 50, 1, 3, -1, -1, 10, 1'b0, nb);
      check_val("stall_bursts", 32'(nb), 2);

      // Randomized frames, levels, restarts and handshake timing.
      for (int k = 0; k < 12; k++) begin
         h     = 13'(2 * $urandom_range(1, 150));
         v     = 13'($urandom_range(1, 12));
         base0 = ADDR_W'($urandom);
         base1 = (k % 3 == 0) ? 28'hFFFFFF0 : ADDR_W'($urandom);
         lvl0  = LVL_W'($urandom_range(0, 460));
         lvl1  = LVL_W'($urandom_range(0, 460));
         start_frame();
         run_frame(0, 6, 1, 6, $urandom_range(0, 6), -1, 400, 1'b1, nb);
      end

      // Restart while the fifth burst (cam0, offset 128) is in flight.
      h     = 13'd1280;
      v     = 13'd720;
      base0 = 28'h0100000;
      base1 = 28'h0800000;
      lvl0  = '0;
      lvl1  = '0;
      start_frame();
      run_frame(1, 2, 2, 3, 4, -1, 8, 1'b0, nb);
      check_val("restart_bursts", 32'(nb), 8);
      cnt = 0;
      while (!rd_req && cnt < 8) begin
         tick();
         cnt++;
      end
      check_val("req_before_rst", 32'(rd_req), 1);

      // Asynchronous reset while a request is pending.
      rst_n = 1'b0;
      #2;
      check_val("arst_req", 32'(rd_req), 0);
      check_val("arst_fields", 32'({rd_sel, rd_len, busy}), 0);
      check_val("arst_addr", 32'(rd_addr), 0);
      tick();
      tick();
      rst_n    = 1'b1;
      fb_m     = 0;
      off_m[0] = 0;
      off_m[1] = 0;
      rr_m     = 1'b1;
      pend_m   = 1'b0;
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (rd_req) cnt++;
      end
      check_val("no_req_after_rst", 32'(cnt), 0);
      check_val("fb_after_rst", 32'(dut.frame_beats), 0);
      h = 13'd20;
      v = 13'd8;
      start_frame();
      run_frame(1, 2, 1, 3, -1, -1, 100, 1'b0, nb);
      check_val("post_rst_bursts", 32'(nb), 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
